tube_tx_port: RTL and testbench
===============================

Name: tube_tx_port

Overview:
- Memory-mapped transmit controller for the Tube register pair the boot firmware drives.
- Status register TubeS1 sits at 0xfffffff8; data register TubeR1 sits at 0xfffffff9.
- CPU writes bytes to TubeR1 and polls TubeS1 bit 6 (via BIT/BVC) for space.
- The block buffers bytes in a FIFO and hands them to the host link over a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  CPU bus select for this port (address decode done outside).
- we  input  1  1 = write, 0 = read; sampled only when cs=1.
- addr  input  1  0 = TubeS1 status, 1 = TubeR1 data.
- din  input  16  CPU write data; only din[7:0] is used.
- dout  output  16  registered read data; bits [15:8] are always 0.
- tx_data  output  8  byte to host link.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  host accepts tx_data this cycle.

Behaviour:
- Reset (async, while reset=1):
  - FIFO empty; pointers and count = 0; overflow flag = 0.
  - dout = 16'h0000, tx_valid = 0, tx_data = 8'h00.
- Status word layout:
  - bit7 = (count != 0).
  - bit6 = (count != DEPTH), i.e. space available; this maps to the V flag so BVC loops while full.
  - bit5 = sticky overflow.
  - bits4:0 = count.
  - other bits = 0.
- Read (cs=1, we=0):
  - dout is loaded at the clock edge; the value is visible the cycle after the request (1-cycle latency, matching the synchronous-memory CPU bus).
  - addr=0 returns the status word.
  - addr=1 returns {8'h00, byte at FIFO head}, or 0 if empty.
  - Reads have no side effects.
  - dout holds its value when no read occurs.
- Data write (cs=1, we=1, addr=1):
  - If count != DEPTH at that edge, din[7:0] is pushed and count increments.
  - If count == DEPTH, the byte is dropped and overflow is set. Fullness is judged before any same-cycle pop, so a write is dropped even if a pop frees a slot that cycle.
- Status write (cs=1, we=1, addr=0):
  - din[5]=1 clears overflow; all other bits are ignored.
  - If a dropped data write and a clear could coincide, set wins. They cannot coincide on a single-port bus; document it and assert in the bench.
- Output stage (registered head; FIFO count includes the head register):
  - tx_valid=1 whenever count != 0, and tx_data = head byte.
  - Once tx_valid=1, tx_data must stay stable until the transfer completes.
  - A transfer completes at an edge where tx_valid && tx_ready: pop, count decrements, the next byte appears the following cycle (no bubble when more bytes are queued).
  - tx_ready while tx_valid=0 is ignored.
- Simultaneous push and pop (not full): count unchanged; ordering stays strictly FIFO.
- Empty-and-push: tx_valid rises the cycle after the write edge with tx_data = pushed byte.
- Pointer wrap: pointers are AW bits and wrap modulo DEPTH naturally; count is AW+1 bits.
- Reset mid-transfer: queued bytes are discarded and tx_valid drops immediately (async). The host must tolerate an aborted byte.
- No combinational path from tx_ready to tx_valid or tx_data.

Test Plan:
- Reset, then read addr=0 -> dout = 16'h0040 one cycle later (empty, space, no overflow); tx_valid = 0.
- With tx_ready=0, write 0x54, 0x36, 0x35 ("T65") to addr=1 -> status reads 16'h00C3. Raise tx_ready for 3 cycles -> tx_data sequence 0x54, 0x36, 0x35 on consecutive cycles; final status 16'h0040.
- Fill DEPTH=4 with tx_ready=0, then write 0xAA -> status 16'h00A4 (nonempty, no space, overflow, count 4); 0xAA never appears on tx_data. Write addr=0 with din=16'h0020 -> status 16'h0084.
- Full FIFO, tx_ready=1 and a data write in the same cycle -> write dropped, overflow set, count becomes 3.
- Count=2, push and pop on the same edge -> count stays 2; the 12 bytes that follow emerge in order across pointer wrap.
- Assert reset while tx_valid=1 and count=3 -> tx_valid=0 and dout=0 immediately; after release, status = 16'h0040.

Source files
------------

// File: rtl/tube_tx_port.sv
// Tube TubeS1/TubeR1 transmit port: the CPU writes bytes into a FIFO and polls status for space,
// and the queued bytes drain to the host link over a valid/ready handshake.
module tube_tx_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic        addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic [15:0]   dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, wr_data, wr_stat, rd, push, pop;
  logic [7:0]    status;

  assign empty      = (count_q == '0);
  assign full       = (count_q == DepthCnt);
  assign wr_data    = cs && we && addr;
  assign wr_stat    = cs && we && !addr;
  assign rd         = cs && !we;
  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  assign push       = wr_data && !full;
  assign pop        = !empty && tx_ready;
  assign rd_ptr_inc = rd_ptr_q + AW'(1);
  assign status     = {!empty, !full, ovf_q, 5'(count_q)};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // head_q mirrors the entry at the read pointer so tx_data comes straight from a flop.
    head_d = head_q;
    if (pop) begin
      if (count_q > (AW+1)'(1)) begin
        head_d = mem_q[rd_ptr_inc];
      end else if (push) begin
        head_d = din[7:0];
      end else begin
        head_d = 8'h00;
      end
    end else if (empty && push) begin
      head_d = din[7:0];
    end

    // A dropped write and a clear cannot share a cycle on one bus; set wins regardless.
    ovf_d = ovf_q;
    if (wr_stat && din[5]) ovf_d = 1'b0;
    if (wr_data && full)   ovf_d = 1'b1;

    dout_d = dout_q;
    if (rd) begin
      dout_d = addr ? {8'h00, (empty ? 8'h00 : head_q)} : {8'h00, status};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
      ovf_q    <= 1'b0;
      dout_q   <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_inc;
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = !empty;
  assign tx_data  = head_q;

endmodule

// File: tb/tb_tube_tx_port.sv
// Randomized and directed bench for tube_tx_port against a queue-based model of the Tube port.
module tb_tube_tx_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, we = 1'b0, addr = 1'b0, tx_ready = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0]  q[$];
  bit          ovf = 1'b0;
  logic [15:0] exp_dout = 16'h0000;
  bit          run = 1'b0;

  tube_tx_port #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] status_word(input int n, input bit o);
    int s = n;
    if (n != 0)     s += 128;
    if (n != DEPTH) s += 64;
    if (o)          s += 32;
    return 16'(s);
  endfunction

  // Applies the port's rules to the model using the inputs held across this edge.
  task automatic model_update();
    int n = q.size();
    bit is_full = (n == DEPTH);
    if (cs && !we) exp_dout = addr ? ((n != 0) ? {8'h00, q[0]} : 16'h0000) : status_word(n, ovf);
    if (cs && we && !addr && din[5]) ovf = 1'b0;
    if (cs && we && addr && is_full) ovf = 1'b1;
    if (n != 0 && tx_ready) void'(q.pop_front());
    if (cs && we && addr && !is_full) q.push_back(din[7:0]);
  endtask

  task automatic model_reset();
    q.delete();
    ovf = 1'b0;
    exp_dout = 16'h0000;
  endtask

  task automatic cyc(input logic c, input logic w, input logic a, input logic [15:0] d,
                     input logic r);
    cs = c; we = w; addr = a; din = d; tx_ready = r;
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (run && !reset) begin
      assert (!((cs && we && addr) && (cs && we && !addr)))
        else $error("data write and status write decoded together");
      chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
      chk("dout", 32'(dout), 32'(exp_dout));
    end
  end

  logic [7:0] t65[3]  = '{8'h54, 8'h36, 8'h35};
  logic [7:0] rest[3] = '{8'h22, 8'h33, 8'h44};

  initial begin
    #2;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    reset = 1'b0;
    model_reset();
    run = 1'b1;

    cyc(1, 0, 0, 16'h0, 0);
    chk("reset_status", 32'(dout), 32'h0040);
    chk("reset_valid", 32'(tx_valid), 32'h0);

    for (int i = 0; i < 3; i++) cyc(1, 1, 1, {8'h00, t65[i]}, 0);
    cyc(1, 0, 0, 16'h0, 0);
    chk("t65_status", 32'(dout), 32'h00C3);
    for (int i = 0; i < 3; i++) begin
      chk("t65_byte", 32'(tx_data), 32'(t65[i]));
      chk("t65_valid", 32'(tx_valid), 32'h1);
      cyc(0, 0, 0, 16'h0, 1);
    end
    cyc(1, 0, 0, 16'h0, 0);
    chk("t65_final", 32'(dout), 32'h0040);

    cyc(1, 1, 1, 16'h0011, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, {8'h00, rest[i]}, 0);
    cyc(1, 1, 1, 16'h00AA, 0);
    cyc(1, 0, 0, 16'h0, 0);
    chk("ovf_status", 32'(dout), 32'h00A4);
    cyc(1, 1, 0, 16'h0020, 0);
    cyc(1, 0, 0, 16'h0, 0);
    chk("ovf_clear", 32'(dout), 32'h0084);

    cyc(1, 1, 1, 16'h00BB, 1);
    cyc(1, 0, 0, 16'h0, 0);
    chk("full_pop_write", 32'(dout), 32'h00E3);
    for (int i = 0; i < 3; i++) begin
      chk("drain_byte", 32'(tx_data), 32'(rest[i]));
      cyc(0, 0, 0, 16'h0, 1);
    end
    cyc(1, 1, 0, 16'h0020, 0);

    cyc(1, 1, 1, 16'h0001, 0);
    cyc(1, 1, 1, 16'h0002, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 16'(8'h10 + i), 1);
    cyc(1, 0, 0, 16'h0, 0);
    chk("pushpop_status", 32'(dout), 32'h00C2);
    chk("wrap_byte0", 32'(tx_data), 32'h1A);
    cyc(1, 0, 1, 16'h0, 1);
    chk("head_read", 32'(dout), 32'h001A);
    chk("wrap_byte1", 32'(tx_data), 32'h1B);
    cyc(0, 0, 0, 16'h0, 1);

    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 16'(8'h60 + i), 0);
    cyc(1, 0, 0, 16'h0, 0);
    chk("pre_rst_status", 32'(dout), 32'h00C3);
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", 32'(tx_valid), 32'h0);
    chk("async_dout", 32'(dout), 32'h0);
    cyc(0, 0, 0, 16'h0, 0);
    reset = 1'b0;
    cyc(1, 0, 0, 16'h0, 0);
    chk("post_rst_status", 32'(dout), 32'h0040);

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
